bus_term_src_fifo: RTL and testbench
====================================

// Module: bus_term_src_fifo
// PURPOSE
//  Per-terminal source queue feeding one terminal slot of bs_gnrtr_n_rbtr.
//  Device side pushes packets; bus side sees pndng/D_pop and pops on grant.
//  First-word fall-through, so D_pop is valid whenever pndng=1.
//  Tracks occupancy, overflow and self-addressed drops for the checker.
// PARAMETERS
//  pckg_sz    16      packet width in bits; dest ID = [pckg_sz-1 -: 8]
//  depth      8       entries, power of two, >=2
//  id         0       this terminal's 8-bit ID
//  broadcast  8'hFF   broadcast dest ID, never dropped by the self-filter
// PORTS
//  clk        in   1                        clock, rising edge
//  reset      in   1                        asynchronous, active-high
//  push       in   1                        device write strobe
//  D_in       in   pckg_sz                  device write data
//  pop        in   1                        from bus arbiter, 1-cycle strobe
//  pndng      out  1                        queue non-empty
//  D_pop      out  pckg_sz                  head entry, to bus D_pop
//  full       out  1                        count == depth
//  count      out  $clog2(depth)+1          occupancy
//  ovf        out  1                        sticky: a push was dropped (full)
//  drop_cnt   out  8                        saturating count of all drops
// BEHAVIOUR
//  Reset (async assert, sync release): rd_ptr=wr_ptr=0, count=0, pndng=0,
//   full=0, ovf=0, drop_cnt=0. D_pop=0 while empty. Memory not cleared.
//  Storage: circular buffer, ptr width $clog2(depth), natural wrap to 0.
//  D_pop = mem[rd_ptr] combinationally. pndng = (count!=0). Both are
//   registered-state derived: no input->output combinational path.
//  Accept rule: push accepted iff
//   - dest != id, or dest == broadcast, and
//   - (count<depth, or pop accepted same cycle).
//  Pop rule: pop accepted iff count!=0. Pop on empty is ignored, no flag.
//  Per-cycle cases, with a = accepted:
//   - push_a only: mem[wr_ptr]<=D_in, wr_ptr++, count++
//   - pop_a only: rd_ptr++, count--
//   - both: write and read, count unchanged. Legal when full and when count=1.
//   - push with count=0 and pop same cycle: pop ignored, push stored.
//     Data becomes visible on D_pop the next cycle.
//  Latency: push accepted at edge N -> pndng=1, D_pop=D_in after edge N.
//  Drops: self-addressed push -> discarded, drop_cnt++ (saturate 255), ovf
//   unchanged. Push on full without pop -> discarded, ovf<=1, drop_cnt++.
//  ovf clears only on reset.
//  Reset mid-operation: all pending entries lost at once, pndng falls
//   asynchronously. A pop in the reset-release cycle is ignored.
//  No FSM states beyond pointers and count; count is the single source of
//   truth for full/empty (no ptr-compare ambiguity).
// STRUCTURE
//  Shared pkg (bus_pkg): ID width const (8), broadcast default,
//   function dest_of(pkt) returning pkt[pckg_sz-1 -: 8].
//  Storage is an inline reg array. No sub-module needed.
//  Instantiated drvrs times beside the DUT: pndng[0][i], D_pop[0][i] and
//   pop[0][i] map one-to-one to this block.
// TESTING
//  1 reset, then push 16'h0112 (id=0) -> next cycle pndng=1, D_pop=16'h0112,
//    count=1.
//  2 push 8 pkts 16'h0100..16'h0107 (depth=8) -> full=1; 9th push ->
//    dropped, ovf=1, drop_cnt=1; pops return 0100..0107 in order, wrap ok.
//  3 full, push+pop same cycle -> count stays 8, new pkt is last out, ovf=0.
//  4 empty, push+pop same cycle -> count=1, pkt retained; pop on empty ->
//    count stays 0.
//  5 id=2: push 16'h02AA -> dropped, drop_cnt=1, pndng=0;
//    push 16'hFFAA -> stored.
//  6 3 entries queued, reset pulsed mid-cycle -> pndng=0 and count=0
//    immediately; 300 drops -> drop_cnt=255.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus-level definitions: terminal ID width, broadcast address and the
// destination-field extractor used by every terminal-side block.
package bus_pkg;

    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
    localparam int MAX_PKT_W = 256;

    // Caller zero-extends its packet to MAX_PKT_W and passes the real width.
    function automatic logic [ID_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                                 input int pkt_w);
        return pkt[pkt_w-1 -: ID_W];
    endfunction

endpackage

// File: rtl/bus_term_src_fifo.sv
// Per-terminal first-word-fall-through source queue. It filters self-addressed
// packets and keeps overflow and drop statistics.
module bus_term_src_fifo
    import bus_pkg::*;
#(
    parameter int              pckg_sz   = 16,
    parameter int              depth     = 8,
    parameter logic [ID_W-1:0] id        = '0,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [pckg_sz-1:0]         D_in,
    input  logic                       pop,
    output logic                       pndng,
    output logic [pckg_sz-1:0]         D_pop,
    output logic                       full,
    output logic [$clog2(depth):0]     count,
    output logic                       ovf,
    output logic [7:0]                 drop_cnt
);

    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(depth);

    logic [pckg_sz-1:0] mem [depth];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic [MAX_PKT_W-1:0] pkt_ext;
    logic [ID_W-1:0]      dest;
    logic                 not_self;
    logic                 pop_a;
    logic                 push_a;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        pkt_ext                = '0;
        pkt_ext[pckg_sz-1:0]   = D_in;
        dest                   = dest_of(pkt_ext, pckg_sz);
        not_self               = (dest != id) || (dest == broadcast);

        pop_a  = pop && (count_q != '0);
        // A simultaneous accepted pop frees the slot, so a full queue can still take data.
        push_a = push && not_self && ((count_q < DEPTH_C) || pop_a);

        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        if (push_a) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_a)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push_a, pop_a})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push && !push_a) begin
            if (not_self) ovf_d = 1'b1;
            if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: storage has no reset; count gates D_pop so stale contents never leak out.
    always_ff @(posedge clk) begin
        if (push_a) mem[wr_ptr_q] <= D_in;
    end

    assign pndng    = (count_q != '0);
    assign D_pop    = pndng ? mem[rd_ptr_q] : '0;
    assign full     = (count_q == DEPTH_C);
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_term_src_fifo.sv
// Self-checking bench for bus_term_src_fifo: directed vector table, hand-written
// reset/filter sequences and randomized traffic against a queue-based model.
module tb_bus_term_src_fifo;

    logic        clk = 1'b0;
    logic        reset, rst2;
    logic        push, pop, push2, pop2;
    logic [15:0] d_in, d_in2;
    logic        pndng, full, ovf, pndng2, full2, ovf2;
    logic [15:0] d_pop, d_pop2;
    logic [3:0]  count, count2;
    logic [7:0]  drop_cnt, drop_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_term_src_fifo dut0 (
        .clk(clk), .reset(reset), .push(push), .D_in(d_in), .pop(pop),
        .pndng(pndng), .D_pop(d_pop), .full(full), .count(count),
        .ovf(ovf), .drop_cnt(drop_cnt)
    );

    bus_term_src_fifo #(.id(8'h02)) dut2 (
        .clk(clk), .reset(rst2), .push(push2), .D_in(d_in2), .pop(pop2),
        .pndng(pndng2), .D_pop(d_pop2), .full(full2), .count(count2),
        .ovf(ovf2), .drop_cnt(drop_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_pndng, input logic [15:0] e_dpop,
                             input logic [3:0] e_cnt, input logic e_full, input logic e_ovf,
                             input logic [7:0] e_drop);
        check({tag, " pndng"},    32'(pndng),    32'(e_pndng));
        check({tag, " D_pop"},    32'(d_pop),    32'(e_dpop));
        check({tag, " count"},    32'(count),    32'(e_cnt));
        check({tag, " full"},     32'(full),     32'(e_full));
        check({tag, " ovf"},      32'(ovf),      32'(e_ovf));
        check({tag, " drop_cnt"}, 32'(drop_cnt), 32'(e_drop));
    endtask

    typedef struct {
        logic        rst;
        logic        push;
        logic [15:0] d;
        logic        pop;
        logic        e_pndng;
        logic [15:0] e_dpop;
        logic [3:0]  e_cnt;
        logic        e_full;
        logic        e_ovf;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic pu, input logic [15:0] d,
                                input logic po, input logic ep, input logic [15:0] ed,
                                input logic [3:0] ec, input logic ef, input logic eo,
                                input logic [7:0] edr);
        vec_t v;
        v = '{r, pu, d, po, ep, ed, ec, ef, eo, edr};
        vecs.push_back(v);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Randomized phase reference model: plain queue plus statistics.
    logic [15:0] model_q[$];
    logic        m_ovf;
    int          m_drop;

    initial begin
        reset = 1'b1; rst2 = 1'b1;
        push = 0; pop = 0; d_in = '0;
        push2 = 0; pop2 = 0; d_in2 = '0;
        tick();
        check_all("reset", 0, 16'h0, 0, 0, 0, 0);
        reset = 1'b0; rst2 = 1'b0;

        // ---- directed vector table ----
        add(0, 1, 16'h0112, 0, 1, 16'h0112, 1, 0, 0, 0);
        add(0, 0, 16'h0,    1, 0, 16'h0,    0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 1, 16'h0100 + 16'(i), 0, 1, 16'h0100, 4'(i + 1), (i == 7), 0, 0);
        add(0, 1, 16'h0108, 0, 1, 16'h0100, 8, 1, 1, 1);
        for (int k = 1; k <= 8; k++)
            add(0, 0, 16'h0, 1, (k < 8), (k < 8) ? 16'h0100 + 16'(k) : 16'h0,
                4'(8 - k), 0, 1, 1);
        add(0, 1, 16'h0200, 0, 1, 16'h0200, 1, 0, 1, 1);
        add(1, 0, 16'h0,    0, 0, 16'h0,    0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 1, 16'h0300 + 16'(i), 0, 1, 16'h0300, 4'(i + 1), (i == 7), 0, 0);
        add(0, 1, 16'h0308, 1, 1, 16'h0301, 8, 1, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(0, 0, 16'h0, 1, (k < 8), (k < 8) ? 16'h0301 + 16'(k) : 16'h0,
                4'(8 - k), 0, 0, 0);
        add(0, 1, 16'h0400, 1, 1, 16'h0400, 1, 0, 0, 0);
        add(0, 0, 16'h0,    1, 0, 16'h0,    0, 0, 0, 0);
        add(0, 0, 16'h0,    1, 0, 16'h0,    0, 0, 0, 0);
        add(0, 1, 16'h00AA, 0, 0, 16'h0,    0, 0, 0, 1);
        add(0, 1, 16'hFF55, 0, 1, 16'hFF55, 1, 0, 0, 1);

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            push  = vecs[i].push;
            d_in  = vecs[i].d;
            pop   = vecs[i].pop;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_pndng, vecs[i].e_dpop,
                      vecs[i].e_cnt, vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_drop);
            reset = 1'b0;
        end
        push = 0; pop = 0;

        // ---- self filter on a terminal with id=2 ----
        push2 = 1; d_in2 = 16'h02AA;
        tick();
        check("id2 self drop_cnt", 32'(drop_cnt2), 32'd1);
        check("id2 self pndng",    32'(pndng2),    32'd0);
        check("id2 self ovf",      32'(ovf2),      32'd0);
        d_in2 = 16'hFFAA;
        tick();
        push2 = 0;
        check("id2 bcast pndng", 32'(pndng2), 32'd1);
        check("id2 bcast D_pop", 32'(d_pop2), 32'hFFAA);
        check("id2 bcast count", 32'(count2), 32'd1);

        // ---- mid-cycle reset with entries queued ----
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 3; i++) begin
            push = 1; d_in = 16'h0500 + 16'(i);
            tick();
        end
        push = 0;
        check("pre-reset count", 32'(count), 32'd3);
        #3 reset = 1'b1;
        #1;
        check("async reset pndng", 32'(pndng), 32'd0);
        check("async reset count", 32'(count), 32'd0);
        check("async reset D_pop", 32'(d_pop), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0; pop = 1'b1;
        tick();
        pop = 1'b0;
        check("release-cycle pop count", 32'(count), 32'd0);

        // ---- drop counter saturation ----
        push = 1;
        for (int i = 0; i < 300; i++) begin
            d_in = {8'h00, 8'(i)};
            tick();
        end
        push = 0;
        check("sat drop_cnt", 32'(drop_cnt), 32'd255);
        check("sat ovf",      32'(ovf),      32'd0);
        check("sat count",    32'(count),    32'd0);

        // ---- randomized traffic vs. queue model ----
        reset = 1; tick(); reset = 0;
        model_q.delete(); m_ovf = 0; m_drop = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        p_push, p_pop, pop_ok, self;
            logic [15:0] dat;
            int          push_pct;
            push_pct = (cyc % 1000 < 500) ? 70 : 35;
            p_push = ($urandom_range(0, 99) < push_pct);
            p_pop  = ($urandom_range(0, 99) < 50);
            dat[7:0] = 8'($urandom);
            case ($urandom_range(0, 5))
                0:       dat[15:8] = 8'h00;
                1:       dat[15:8] = 8'hFF;
                default: dat[15:8] = 8'($urandom);
            endcase
            push = p_push; pop = p_pop; d_in = dat;

            pop_ok = p_pop && (model_q.size() != 0);
            self   = (dat[15:8] == 8'h00);
            if (pop_ok) void'(model_q.pop_front());
            if (p_push) begin
                if (self) begin
                    if (m_drop < 255) m_drop++;
                end else if (model_q.size() < 8) begin
                    model_q.push_back(dat);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end

            tick();
            check("rnd", {pndng, full, ovf, count, drop_cnt, d_pop},
                  {model_q.size() != 0, model_q.size() == 8, m_ovf, 4'(model_q.size()),
                   8'(m_drop), (model_q.size() != 0) ? model_q[0] : 16'h0});
        end
        push = 0; pop = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
